// File: rtl/row_package_feeder.sv
// Streams one matrix row and the matching vector, package by package, from two
// package-addressed memories into the downstream dot-product stage.
module row_package_feeder #(
  parameter int ELEMENT_WIDTH    = 32,
  parameter int NO_OF_UNITS      = 8,
  parameter int ADDR_WIDTH       = 10,
  parameter int PACKAGE_INTERVAL = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [31:0]                          total,
  input  logic [ADDR_WIDTH-1:0]                row_base_addr,
  input  logic [ADDR_WIDTH-1:0]                vec_base_addr,
  output logic                                 row_mem_rd_en,
  output logic                                 vec_mem_rd_en,
  output logic [ADDR_WIDTH-1:0]                row_mem_addr,
  output logic [ADDR_WIDTH-1:0]                vec_mem_addr,
  input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] row_mem_data,
  input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] vec_mem_data,
  input  logic                                 downstream_ready,
  output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] first_row_output,
  output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] second_row_output,
  output logic                                 read_now,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 error
);

  localparam int          PW        = ELEMENT_WIDTH * NO_OF_UNITS;
  localparam logic [31:0] UNITS32   = 32'(NO_OF_UNITS);
  localparam logic [31:0] HOLD_LAST = 32'(PACKAGE_INTERVAL - 2);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, PRESENT, HOLD, DONE} state_t;

  state_t                state_q, state_d;
  logic [31:0]           idx_q, idx_d;
  logic [31:0]           last_q, last_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] rb_q, rb_d, vb_q, vb_d;
  logic [ADDR_WIDTH-1:0] ra_q, ra_d, va_q, va_d;
  logic [PW-1:0]         first_q, first_d, second_q, second_d;
  logic                  read_now_q, read_now_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  advance;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    rb_d       = rb_q;
    vb_d       = vb_q;
    ra_d       = ra_q;
    va_d       = va_q;
    first_d    = first_q;
    second_d   = second_q;
    read_now_d = 1'b0;
    error_d    = 1'b0;
    advance    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (total == '0 || (total % UNITS32) != '0) begin
            error_d = 1'b1;
          end else begin
            last_d  = (total / UNITS32) - 32'd1;
            rb_d    = row_base_addr;
            vb_d    = vec_base_addr;
            ra_d    = row_base_addr;
            va_d    = vec_base_addr;
            idx_d   = '0;
            state_d = FETCH;
          end
        end
      end
      FETCH:   if (downstream_ready) state_d = WAIT;
      WAIT: begin
        first_d    = row_mem_data;
        second_d   = vec_mem_data;
        read_now_d = 1'b1;
        state_d    = PRESENT;
      end
      PRESENT: begin
        if (PACKAGE_INTERVAL == 1) begin
          advance = 1'b1;
        end else begin
          cnt_d   = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) advance = 1'b1;
        else                    cnt_d   = cnt_q + 32'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Address registers are loaded on the way into FETCH so they are stable
    // for the whole FETCH wait, however long downstream_ready stays low.
    if (advance) begin
      if (idx_q == last_q) begin
        state_d = DONE;
      end else begin
        idx_d   = idx_q + 32'd1;
        ra_d    = rb_q + ADDR_WIDTH'(idx_q + 32'd1);
        va_d    = vb_q + ADDR_WIDTH'(idx_q + 32'd1);
        state_d = FETCH;
      end
    end

    busy_d = (state_d == FETCH) || (state_d == WAIT) ||
             (state_d == PRESENT) || (state_d == HOLD);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      last_q     <= '0;
      cnt_q      <= '0;
      rb_q       <= '0;
      vb_q       <= '0;
      ra_q       <= '0;
      va_q       <= '0;
      first_q    <= '0;
      second_q   <= '0;
      read_now_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      rb_q       <= rb_d;
      vb_q       <= vb_d;
      ra_q       <= ra_d;
      va_q       <= va_d;
      first_q    <= first_d;
      second_q   <= second_d;
      read_now_q <= read_now_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // The strobe must react to downstream_ready within the same FETCH cycle,
  // so it is a registered state qualified by the live ready input.
  assign row_mem_rd_en     = (state_q == FETCH) && downstream_ready;
  assign vec_mem_rd_en     = (state_q == FETCH) && downstream_ready;
  assign row_mem_addr      = ra_q;
  assign vec_mem_addr      = va_q;
  assign first_row_output  = first_q;
  assign second_row_output = second_q;
  assign read_now          = read_now_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign error             = error_q;

endmodule

// File: tb/tb_row_package_feeder.sv
// Directed bench for row_package_feeder: cycle c is the period after edge c-1,
// where edge 0 is the edge that samples start.
module tb_row_package_feeder;

  localparam int EW = 32;
  localparam int NU = 8;
  localparam int AW = 10;
  localparam int PW = EW * NU;
  localparam int MAXC = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   total = '0;
  logic [AW-1:0] row_base_addr = '0, vec_base_addr = '0;
  logic          row_mem_rd_en, vec_mem_rd_en;
  logic [AW-1:0] row_mem_addr, vec_mem_addr;
  logic [PW-1:0] row_mem_data = '0, vec_mem_data = '0;
  logic          downstream_ready = 1'b1;
  logic [PW-1:0] first_row_output, second_row_output;
  logic          read_now, busy, done, error;

  int errors = 0;
  int checks = 0;

  logic          tr_rrd[1:MAXC], tr_vrd[1:MAXC], tr_rn[1:MAXC];
  logic          tr_busy[1:MAXC], tr_done[1:MAXC], tr_err[1:MAXC];
  logic [AW-1:0] tr_ra[1:MAXC], tr_va[1:MAXC];
  logic [PW-1:0] tr_f[1:MAXC], tr_s[1:MAXC];

  row_package_feeder #(
    .ELEMENT_WIDTH(EW), .NO_OF_UNITS(NU), .ADDR_WIDTH(AW), .PACKAGE_INTERVAL(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .total(total),
    .row_base_addr(row_base_addr), .vec_base_addr(vec_base_addr),
    .row_mem_rd_en(row_mem_rd_en), .vec_mem_rd_en(vec_mem_rd_en),
    .row_mem_addr(row_mem_addr), .vec_mem_addr(vec_mem_addr),
    .row_mem_data(row_mem_data), .vec_mem_data(vec_mem_data),
    .downstream_ready(downstream_ready),
    .first_row_output(first_row_output), .second_row_output(second_row_output),
    .read_now(read_now), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] row_pat(input logic [AW-1:0] a);
    logic [PW-1:0] r;
    for (int k = 0; k < NU; k++) r[k*EW +: EW] = 32'hA000_0000 | (32'(a) << 8) | 32'(k);
    return r;
  endfunction

  function automatic logic [PW-1:0] vec_pat(input logic [AW-1:0] a);
    logic [PW-1:0] r;
    for (int k = 0; k < NU; k++) r[k*EW +: EW] = 32'hB000_0000 | (32'(a) << 8) | 32'(k);
    return r;
  endfunction

  // Synchronous-read memories: data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (row_mem_rd_en) row_mem_data <= row_pat(row_mem_addr);
    if (vec_mem_rd_en) vec_mem_data <= vec_pat(vec_mem_addr);
  end

  task automatic run(input logic [31:0] tot, input logic [AW-1:0] rb, input logic [AW-1:0] vb,
                     input int n, input int lo_from, input int lo_to,
                     input int restart_c, input int reset_c);
    total = tot; row_base_addr = rb; vec_base_addr = vb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= n; c++) begin
      downstream_ready = !(c >= lo_from && c <= lo_to);
      start = (c == restart_c);
      reset = (c == reset_c);
      if (c == restart_c) begin
        total = 32'd8; row_base_addr = 10'h100; vec_base_addr = 10'h200;
      end
      #1;
      tr_rrd[c] = row_mem_rd_en; tr_vrd[c] = vec_mem_rd_en; tr_rn[c] = read_now;
      tr_busy[c] = busy; tr_done[c] = done; tr_err[c] = error;
      tr_ra[c] = row_mem_addr; tr_va[c] = vec_mem_addr;
      tr_f[c] = first_row_output; tr_s[c] = second_row_output;
      @(posedge clk); #1;
      start = 1'b0; reset = 1'b0;
    end
    downstream_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; total = 32'd16;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, error, read_now, row_mem_rd_en, vec_mem_rd_en} !== 6'b0) begin
      errors++; $display("FAIL reset_status: got %b expected 000000",
                         {busy, done, error, read_now, row_mem_rd_en, vec_mem_rd_en});
    end
    checks++;
    if ({row_mem_addr, vec_mem_addr} !== '0) begin
      errors++; $display("FAIL reset_addr: got %h/%h expected 0/0", row_mem_addr, vec_mem_addr);
    end
    checks++;
    if ({first_row_output, second_row_output} !== '0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", first_row_output);
    end
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
  endtask

  // Two-package stream with base addresses b_r/b_v, first strobe in cycle f,
  // previous package contents prev_r/prev_v before the first capture.
  task automatic check_stream(input string nm, input int f, input int n,
                              input logic [AW-1:0] b_r, input logic [AW-1:0] b_v,
                              input logic [PW-1:0] prev_r, input logic [PW-1:0] prev_v);
    logic [AW-1:0] a1r, a1v;
    logic [PW-1:0] er, ev;
    a1r = b_r + 10'd1; a1v = b_v + 10'd1;
    for (int c = 1; c <= n; c++) begin
      logic erd, ern;
      erd = (c == f) || (c == f + 4);
      ern = (c == f + 2) || (c == f + 6);
      checks++;
      if (tr_rrd[c] !== erd || tr_vrd[c] !== erd) begin
        errors++; $display("FAIL %s_rd_en c%0d: got %b%b expected %b", nm, c, tr_rrd[c], tr_vrd[c], erd);
      end
      if (c == f || c == f + 4) begin
        checks++;
        if (tr_ra[c] !== (c == f ? b_r : a1r) || tr_va[c] !== (c == f ? b_v : a1v)) begin
          errors++; $display("FAIL %s_addr c%0d: got %h/%h expected %h/%h", nm, c, tr_ra[c], tr_va[c],
                             (c == f ? b_r : a1r), (c == f ? b_v : a1v));
        end
      end
      checks++;
      if (tr_rn[c] !== ern) begin
        errors++; $display("FAIL %s_read_now c%0d: got %b expected %b", nm, c, tr_rn[c], ern);
      end
      checks++;
      if (tr_done[c] !== (c == f + 8)) begin
        errors++; $display("FAIL %s_done c%0d: got %b expected %b", nm, c, tr_done[c], c == f + 8);
      end
      checks++;
      if (tr_busy[c] !== (c >= 1 && c <= f + 7)) begin
        errors++; $display("FAIL %s_busy c%0d: got %b expected %b", nm, c, tr_busy[c], c <= f + 7);
      end
      checks++;
      if (tr_err[c] !== 1'b0) begin
        errors++; $display("FAIL %s_error c%0d: got %b expected 0", nm, c, tr_err[c]);
      end
      if (c < f + 2)      begin er = prev_r;       ev = prev_v;       end
      else if (c < f + 6) begin er = row_pat(b_r); ev = vec_pat(b_v); end
      else                begin er = row_pat(a1r); ev = vec_pat(a1v); end
      checks++;
      if (tr_f[c] !== er || tr_s[c] !== ev) begin
        errors++; $display("FAIL %s_data c%0d: got %h expected %h", nm, c, tr_f[c][31:0], er[31:0]);
      end
    end
  endtask

  task automatic test_ready_stall();
    run(32'd16, 10'h050, 10'h060, 14, 1, 4, 0, 0);
    check_stream("stall", 5, 14, 10'h050, 10'h060, '0, '0);
  endtask

  task automatic test_basic();
    run(32'd16, 10'h010, 10'h020, 11, 0, -1, 0, 0);
    check_stream("basic", 1, 11, 10'h010, 10'h020, row_pat(10'h051), vec_pat(10'h061));
  endtask

  task automatic test_error();
    logic [31:0] bad[2];
    bad[0] = 32'd12; bad[1] = 32'd0;
    for (int t = 0; t < 2; t++) begin
      run(bad[t], 10'h010, 10'h020, 4, 0, -1, 0, 0);
      for (int c = 1; c <= 4; c++) begin
        checks++;
        if (tr_err[c] !== (c == 1)) begin
          errors++; $display("FAIL error_pulse total=%0d c%0d: got %b expected %b", bad[t], c, tr_err[c], c == 1);
        end
        checks++;
        if ({tr_rrd[c], tr_vrd[c], tr_busy[c], tr_rn[c], tr_done[c]} !== 5'b0) begin
          errors++; $display("FAIL error_quiet total=%0d c%0d: got %b expected 00000", bad[t], c,
                             {tr_rrd[c], tr_vrd[c], tr_busy[c], tr_rn[c], tr_done[c]});
        end
      end
    end
  endtask

  task automatic test_wrap();
    run(32'd16, 10'h3FF, 10'h3FE, 10, 0, -1, 0, 0);
    check_stream("wrap", 1, 10, 10'h3FF, 10'h3FE, row_pat(10'h011), vec_pat(10'h021));
    checks++;
    if (tr_ra[5] !== 10'h000) begin
      errors++; $display("FAIL wrap_addr0: got %h expected 000", tr_ra[5]);
    end
  endtask

  task automatic test_back_to_back_start();
    int nrn, ndone;
    run(32'd16, 10'h010, 10'h020, 14, 0, -1, 2, 0);
    check_stream("restart", 1, 14, 10'h010, 10'h020, row_pat(10'h000), vec_pat(10'h3FF));
    nrn = 0; ndone = 0;
    for (int c = 1; c <= 14; c++) begin
      nrn += int'(tr_rn[c]); ndone += int'(tr_done[c]);
    end
    checks++;
    if (nrn != 2 || ndone != 1) begin
      errors++; $display("FAIL restart_counts: got read_now=%0d done=%0d expected 2/1", nrn, ndone);
    end
  endtask

  task automatic test_reset_midstream();
    run(32'd32, 10'h070, 10'h080, 8, 0, -1, 0, 4);
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if (tr_busy[c] !== (c <= 4)) begin
        errors++; $display("FAIL abort_busy c%0d: got %b expected %b", c, tr_busy[c], c <= 4);
      end
      if (c >= 5) begin
        checks++;
        if ({tr_rrd[c], tr_vrd[c], tr_rn[c], tr_done[c], tr_err[c]} !== 5'b0 ||
            tr_ra[c] !== '0 || tr_va[c] !== '0 || tr_f[c] !== '0 || tr_s[c] !== '0) begin
          errors++; $display("FAIL abort_zero c%0d: got rd=%b rn=%b done=%b err=%b addr=%h data=%h expected all 0",
                             c, tr_rrd[c], tr_rn[c], tr_done[c], tr_err[c], tr_ra[c], tr_f[c][31:0]);
        end
      end
    end
    run(32'd16, 10'h030, 10'h040, 10, 0, -1, 0, 0);
    check_stream("after_abort", 1, 10, 10'h030, 10'h040, '0, '0);
  endtask

  initial begin
    test_reset();
    test_ready_stall();
    test_basic();
    test_error();
    test_wrap();
    test_back_to_back_start();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/row_package_feeder.md
ROW_PACKAGE_FEEDER -- requirements
Module: row_package_feeder

Interface
REQ-001 Parameter ELEMENT_WIDTH, default 32, bit width of one matrix/vector element.
REQ-002 Parameter NO_OF_UNITS, default 8, elements per package.
REQ-003 Parameter ADDR_WIDTH, default 10, package-address width of both source memories.
REQ-004 Parameter PACKAGE_INTERVAL, default 2, minimum 1, cycles the package is held stable from the read_now cycle on.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  request to stream one row; sampled only in IDLE.
REQ-008 total  input  32  elements per row; sampled with start.
REQ-009 row_base_addr, vec_base_addr  input  ADDR_WIDTH each  first package address in the row and vector memories; sampled with start.
REQ-010 row_mem_rd_en, vec_mem_rd_en  output  1 each  memory read strobes.
REQ-011 row_mem_addr, vec_mem_addr  output  ADDR_WIDTH each  memory package addresses.
REQ-012 row_mem_data, vec_mem_data  input  ELEMENT_WIDTH*NO_OF_UNITS each  read data, valid the cycle after the rd_en cycle.
REQ-013 downstream_ready  input  1  dot-product stage can accept a new package.
REQ-014 first_row_output, second_row_output  output  ELEMENT_WIDTH*NO_OF_UNITS each  package to the downstream dot-product stage (row, vector).
REQ-015 read_now  output  1  one-cycle pulse marking a new valid package.
REQ-016 busy, done, error  output  1 each  status.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, WAIT, PRESENT, HOLD, DONE; all outputs registered.
REQ-018 IDLE: on start=1 with total!=0 and total%NO_OF_UNITS==0, latch pkg_count=total/NO_OF_UNITS, both bases, pkg_idx=0, go FETCH.
REQ-019 IDLE: on start=1 with total==0 or total not a multiple of NO_OF_UNITS, pulse error one cycle, stay IDLE, issue no memory read.
REQ-020 FETCH: if downstream_ready=1, assert both rd_en one cycle with addr=base+pkg_idx (modulo 2^ADDR_WIDTH) and go WAIT; else stay FETCH with rd_en=0.
REQ-021 WAIT: capture row_mem_data/vec_mem_data into the output registers; go PRESENT.
REQ-022 PRESENT: read_now=1 for exactly this cycle, outputs hold captured package; go HOLD, or to the post-HOLD decision directly if PACKAGE_INTERVAL==1.
REQ-023 HOLD: remain PACKAGE_INTERVAL-1 cycles with outputs stable; then if pkg_idx==pkg_count-1 go DONE, else pkg_idx+1 and go FETCH.
REQ-024 DONE: done=1 for one cycle, go IDLE; first/second_row_output keep last package until next capture or reset.
REQ-025 busy SHALL be 1 in FETCH, WAIT, PRESENT, HOLD; 0 in IDLE and DONE.
REQ-026 start while not in IDLE SHALL be ignored; total and bases changes while busy have no effect.
REQ-027 Minimum per-package period SHALL be PACKAGE_INTERVAL+2 cycles; first read_now 3 cycles after the start-sampling edge with downstream_ready=1.
REQ-028 Output data SHALL change only in the cycle following WAIT, never during PRESENT or HOLD.

Reset
REQ-029 reset=1 SHALL force IDLE, pkg_idx=0, and busy, done, error, read_now, both rd_en, both addr, both data outputs to 0 on the next edge, overriding all else including start.
REQ-030 reset asserted mid-stream SHALL abort without done or error; next start restarts from pkg_idx=0.

Verification
REQ-031 total=16, bases 0x010/0x020, ready=1, interval 2, start at edge 0 -> rd_en cycles 1,5 addresses 0x010/0x020 then 0x011/0x021; read_now cycles 3,7; done cycle 9; busy cycles 1-8.
REQ-032 total=12 (and separately total=0) -> error=1 cycle 1 only, no rd_en, busy stays 0.
REQ-033 total=16, downstream_ready low cycles 1-4 -> first rd_en cycle 5, read_now cycle 7, outputs unchanged before cycle 7.
REQ-034 row_base_addr=0x3FF, ADDR_WIDTH=10, total=16 -> addresses 0x3FF then 0x000.
REQ-035 reset at cycle 4 (HOLD) of a total=32 stream -> all outputs 0 from cycle 5, no done; fresh start completes normally.
REQ-036 start pulsed again at cycle 2 of a total=16 stream -> ignored; exactly two read_now and one done.
